// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game-level constants: default button count, button
//                index assignments and default lockout length.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int NUM_BTN_DEFAULT        = 4;
    localparam int LOCKOUT_CYCLES_DEFAULT = 10000;
    localparam int LOCK_W_DEFAULT         = 20;

    // Button index assignments on the press bus
    localparam int BTN_P1    = 0;
    localparam int BTN_P2    = 1;
    localparam int BTN_SERVE = 2;
    localparam int BTN_PAUSE = 3;

endpackage
`default_nettype wire

// File: rtl/press_event_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : press_event_arbiter_if
//  Description : Valid/ready event stream from the press arbiter to the game
//                state machine.
//                evt_valid - event available (producer)
//                evt_id    - button index of the event (producer)
//                evt_ready - consumer accepts the event (consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface press_event_arbiter_if #(
    parameter int ID_W = $clog2(game_pkg::NUM_BTN_DEFAULT)
) ();

    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;

    modport master (
        output evt_valid,
        output evt_id,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        output evt_ready
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches i_cand upward from
//                (i_last_grant + 1) mod NUM_BTN with wrap-around and returns
//                the first set bit as one-hot and encoded index.
//                i_cand       - candidate requests
//                i_last_grant - index granted most recently
//                o_grant      - one-hot grant (zero when no candidate)
//                o_grant_idx  - encoded grant index
//                o_grant_any  - a candidate was found
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import game_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEFAULT,
    parameter int ID_W    = $clog2(NUM_BTN)
) (
    input  logic [NUM_BTN-1:0] i_cand,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [NUM_BTN-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_grant_any
);

    always_comb begin
        int              pos;
        logic [ID_W-1:0] idx;
        pos         = 0;
        idx         = '0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            // Sum stays below 2*NUM_BTN, so one subtraction wraps it; this
            // also covers non-power-of-2 button counts.
            pos = int'(i_last_grant) + k;
            if (pos >= NUM_BTN) begin
                pos = pos - NUM_BTN;
            end
            idx = ID_W'(pos);
            if (!o_grant_any && i_cand[idx]) begin
                o_grant_any  = 1'b1;
                o_grant_idx  = idx;
                o_grant[idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/press_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : press_event_arbiter
//  Description : Serialises one-cycle button press pulses into a single
//                valid/ready event stream with round-robin fairness,
//                per-button lockout after each grant and sticky overrun flags.
//                clk         - system clock
//                reset       - synchronous, active-high reset
//                enable      - accept new presses when high
//                press       - one-cycle press pulses, bit i = button i
//                evt         - event stream (master side)
//                overrun     - sticky: press while same button still pending
//                clr_overrun - one-cycle pulse clearing all overrun bits
//                locked      - bit i high while button i is in lockout
//  Revision    : 1.0 - initial release
// ============================================================================
module press_event_arbiter
    import game_pkg::*;
#(
    parameter int NUM_BTN        = NUM_BTN_DEFAULT,
    parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEFAULT,
    parameter int LOCK_W         = LOCK_W_DEFAULT,
    parameter int ID_W           = $clog2(NUM_BTN)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_BTN-1:0]          press,
    press_event_arbiter_if.master       evt,
    output logic [NUM_BTN-1:0]          overrun,
    input  logic                        clr_overrun,
    output logic [NUM_BTN-1:0]          locked
);

    localparam logic [LOCK_W-1:0] c_LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
    // Pointer starts on the last button so button 0 is searched first
    localparam logic [ID_W-1:0]   c_PTR_RESET = ID_W'(NUM_BTN - 1);

    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] r_overrun;
    logic               r_evt_valid;
    logic [ID_W-1:0]    r_evt_id;
    logic [ID_W-1:0]    r_last_grant;

    logic [NUM_BTN-1:0] w_locked;
    logic [NUM_BTN-1:0] w_req;
    logic [NUM_BTN-1:0] w_cand;
    logic [NUM_BTN-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_grant_any;
    logic               w_load;
    logic [NUM_BTN-1:0] w_take;
    logic [NUM_BTN-1:0] w_ov_set;

    assign w_req  = press & {NUM_BTN{enable}} & ~w_locked;
    // A fresh press is grantable in the same cycle it arrives
    assign w_cand = r_pending | w_req;

    rr_arbiter #(
        .NUM_BTN (NUM_BTN),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_cand       (w_cand),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_grant_any  (w_grant_any)
    );

    assign w_load = (!r_evt_valid || evt.evt_ready) && w_grant_any;
    assign w_take = w_grant & {NUM_BTN{w_load}};
    // A press coinciding with its own grant is absorbed, not an overrun
    assign w_ov_set = w_req & r_pending & ~w_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= '0;
            r_overrun    <= '0;
            r_evt_valid  <= 1'b0;
            r_evt_id     <= '0;
            r_last_grant <= c_PTR_RESET;
        end else begin
            r_pending <= enable ? (w_cand & ~w_take) : '0;
            // Set has priority over a coincident clear
            r_overrun <= (r_overrun & ~{NUM_BTN{clr_overrun}}) | w_ov_set;
            if (w_load) begin
                r_evt_valid  <= 1'b1;
                r_evt_id     <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end else if (evt.evt_ready) begin
                r_evt_valid  <= 1'b0;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_lock
            logic [LOCK_W-1:0] r_lock_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_lock_cnt <= '0;
                end else if (w_take[i]) begin
                    r_lock_cnt <= c_LOCK_LOAD;
                end else if (r_lock_cnt != '0) begin
                    r_lock_cnt <= r_lock_cnt - 1'b1;
                end
            end

            assign w_locked[i] = (r_lock_cnt != '0);
        end
    endgenerate

    assign evt.evt_valid = r_evt_valid;
    assign evt.evt_id    = r_evt_id;
    assign overrun       = r_overrun;
    assign locked        = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_press_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_press_event_arbiter
//  Description : Self-checking bench for press_event_arbiter: directed
//                scenarios with literal expectations, then randomized
//                stimulus compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_press_event_arbiter;

    localparam int NB  = 4;
    localparam int LCK = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [NB-1:0] press;
    logic [NB-1:0] overrun;
    logic          clr_overrun;
    logic [NB-1:0] locked;

    int total = 0;
    int bad   = 0;

    press_event_arbiter_if #(.ID_W(2)) evt ();

    press_event_arbiter #(
        .NUM_BTN        (NB),
        .LOCKOUT_CYCLES (LCK),
        .LOCK_W         (20),
        .ID_W           (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .press       (press),
        .evt         (evt),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        press = '0;
        tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: button masks held as ints, lockouts as counters
    // ------------------------------------------------------------------
    int m_pend, m_ov, m_id, m_last;
    int m_cnt [NB];
    bit m_valid;
    bit m_known = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pend  = 0;
            m_ov    = 0;
            m_valid = 1'b0;
            m_id    = 0;
            m_last  = NB - 1;
            for (int i = 0; i < NB; i++) m_cnt[i] = 0;
            m_known = 1'b1;
        end else begin
            int  req, cand, g, pidx;
            bit  load;
            req = 0;
            for (int i = 0; i < NB; i++)
                if (((int'(press) >> i) & 1) == 1 && enable && m_cnt[i] == 0)
                    req |= (1 << i);
            cand = m_pend | req;
            load = (!m_valid || evt.evt_ready) && cand != 0;
            g = -1;
            if (load)
                for (int k = 1; k <= NB; k++) begin
                    pidx = (m_last + k) % NB;
                    if (g < 0 && ((cand >> pidx) & 1) == 1) g = pidx;
                end
            for (int i = 0; i < NB; i++) begin
                bit ovs;
                ovs = ((req >> i) & 1) == 1 && ((m_pend >> i) & 1) == 1 && i != g;
                if (clr_overrun) m_ov &= ~(1 << i);
                if (ovs) m_ov |= (1 << i);
            end
            if (!enable) m_pend = 0;
            else begin
                m_pend = cand;
                if (g >= 0) m_pend &= ~(1 << g);
            end
            for (int i = 0; i < NB; i++) begin
                if (i == g) m_cnt[i] = LCK;
                else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            end
            if (load) begin
                m_valid = 1'b1;
                m_id    = g;
                m_last  = g;
            end else if (evt.evt_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare process: registered outputs checked mid-cycle
    always @(negedge clk) begin
        int exp_lock;
        if (m_known) begin
            exp_lock = 0;
            for (int i = 0; i < NB; i++) if (m_cnt[i] != 0) exp_lock |= (1 << i);
            check("mdl_evt_valid", int'(evt.evt_valid), int'(m_valid));
            if (m_valid) check("mdl_evt_id", int'(evt.evt_id), m_id);
            check("mdl_overrun", int'(overrun), m_ov);
            check("mdl_locked", int'(locked), exp_lock);
        end
    end

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        press         = '0;
        clr_overrun   = 1'b0;
        evt.evt_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_valid", int'(evt.evt_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_locked", int'(locked), 0);

        // 1: single press, one-cycle latency, 8-cycle lockout
        press = 4'b0100; tick(); press = '0;
        check("t1_valid", int'(evt.evt_valid), 1);
        check("t1_id", int'(evt.evt_id), 2);
        check("t1_locked", int'(locked), 4'b0100);
        tick();
        check("t1_single", int'(evt.evt_valid), 0);
        repeat (6) tick();
        check("t1_lock_last", int'(locked), 4'b0100);
        tick();
        check("t1_lock_free", int'(locked), 0);

        // 2: simultaneous presses, round-robin order
        do_reset();
        press = 4'b0011; tick(); press = '0;
        check("t2_first", int'(evt.evt_id), 0);
        tick();
        check("t2_second_v", int'(evt.evt_valid), 1);
        check("t2_second", int'(evt.evt_id), 1);
        tick();
        check("t2_idle", int'(evt.evt_valid), 0);
        repeat (10) tick();
        press = 4'b0001; tick(); press = '0;
        check("t2_ptr0", int'(evt.evt_id), 0);
        repeat (10) tick();
        press = 4'b1001; tick(); press = '0;
        check("t2_wrap_a", int'(evt.evt_id), 3);
        tick();
        check("t2_wrap_b_v", int'(evt.evt_valid), 1);
        check("t2_wrap_b", int'(evt.evt_id), 0);

        // 3: backpressure holds id, then back-to-back transfer
        do_reset();
        evt.evt_ready = 1'b0;
        press = 4'b0010; tick();
        press = 4'b1000; tick(); press = '0;
        check("t3_hold_v", int'(evt.evt_valid), 1);
        check("t3_hold", int'(evt.evt_id), 1);
        repeat (2) tick();
        check("t3_stable", int'(evt.evt_id), 1);
        evt.evt_ready = 1'b1; tick();
        check("t3_next_v", int'(evt.evt_valid), 1);
        check("t3_next", int'(evt.evt_id), 3);
        tick();
        check("t3_drain", int'(evt.evt_valid), 0);

        // 4: overrun while pending, then clear
        do_reset();
        evt.evt_ready = 1'b0;
        press = 4'b0001; tick();
        press = 4'b0010; tick();
        press = 4'b0010; tick(); press = '0;
        check("t4_overrun", int'(overrun), 4'b0010);
        check("t4_head", int'(evt.evt_id), 0);
        evt.evt_ready = 1'b1; tick();
        check("t4_one_v", int'(evt.evt_valid), 1);
        check("t4_one", int'(evt.evt_id), 1);
        tick();
        check("t4_only_one", int'(evt.evt_valid), 0);
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        check("t4_cleared", int'(overrun), 0);

        // 5: press during lockout dropped, later press accepted
        do_reset();
        press = 4'b0001; tick(); press = '0;
        check("t5_first", int'(evt.evt_id), 0);
        repeat (2) tick();
        press = 4'b0001; tick(); press = '0;
        check("t5_dropped", int'(evt.evt_valid), 0);
        check("t5_no_ovr", int'(overrun), 0);
        repeat (6) tick();
        press = 4'b0001; tick(); press = '0;
        check("t5_again_v", int'(evt.evt_valid), 1);
        check("t5_again", int'(evt.evt_id), 0);

        // 6: enable low masks presses; reset discards held event
        do_reset();
        enable = 1'b0;
        press = 4'b1111; tick(); press = '0;
        check("t6_masked", int'(evt.evt_valid), 0);
        tick();
        check("t6_masked2", int'(evt.evt_valid), 0);
        enable = 1'b1;
        evt.evt_ready = 1'b0;
        press = 4'b0110; tick(); press = '0;
        check("t6_held", int'(evt.evt_id), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_rst_v", int'(evt.evt_valid), 0);
        evt.evt_ready = 1'b1; tick();
        check("t6_no_pend", int'(evt.evt_valid), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 299) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            press         = ($urandom_range(0, 2) == 0) ? NB'($urandom) : '0;
            evt.evt_ready = ($urandom_range(0, 9) < 7);
            clr_overrun   = ($urandom_range(0, 19) == 0);
            tick();
        end
        reset = 1'b0; press = '0; clr_overrun = 1'b0; evt.evt_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/press_event_arbiter.md
Name: press_event_arbiter

Overview:
- Collects single-cycle press pulses from NUM_BTN debounced buttons (both players' paddles, serve, pause) and serialises them into one event stream for the game FSM.
- Uses round-robin priority, so simultaneous presses from two players are never lost and neither player is favoured.
- Applies a per-button lockout after each granted event and flags presses that overrun a still-pending event.
- Sits between the per-button debouncers and the game state machine.

Parameters:
NUM_BTN, 4, number of button request inputs (>=2)
LOCKOUT_CYCLES, 10000, cycles a button is ignored after its event is granted; 0 disables lockout
LOCK_W, 20, width of each lockout counter; must hold LOCKOUT_CYCLES
ID_W, $clog2(NUM_BTN), width of event id

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  accept new presses when high
press  in  NUM_BTN  one-cycle press pulses from debouncers, bit i = button i
evt_valid  out  1  event available
evt_id  out  ID_W  index of button for current event
evt_ready  in  1  consumer accepts event (transfer when evt_valid && evt_ready)
overrun  out  NUM_BTN  sticky per-button flag: press arrived while same button already pending
clr_overrun  in  1  one-cycle pulse, clears all overrun bits
locked  out  NUM_BTN  bit i high while button i is in lockout

Behaviour:
- Reset:
  - pending, overrun, evt_valid, evt_id and all lockout counters go to 0.
  - The round-robin pointer resets so button 0 has highest priority.
  - Reset mid-operation discards any held event and all pending presses.
- Accept:
  - req[i] = press[i] && enable && !locked[i].
  - Masked presses are dropped silently and do not set overrun.
- Pending:
  - pending[i] sets on req[i] and clears when button i is granted.
  - req[i] while pending[i] is already 1 sets overrun[i]; pending stays 1, so only one event is queued per button.
- Enable low: pending clears to 0 on the next edge. A held evt_valid stays until accepted.
- Candidates: cand = pending | req, so a fresh press is grantable in the same cycle.
- Load condition: the output register loads when (!evt_valid || evt_ready) and cand != 0. Otherwise evt_valid/evt_id hold, and once evt_valid is high evt_id is stable until transfer.
- Grant:
  - Pick the first set cand bit, searching upward from (last_grant+1) mod NUM_BTN with wrap-around.
  - On grant: evt_valid<=1, evt_id<=granted index, pending[granted]<=0, last_grant<=granted, lockout counter[granted]<=LOCKOUT_CYCLES.
- Transfer with nothing to load: evt_valid<=0 on the next edge.
- Back-to-back: transfer and a new grant in the same cycle give a new event with no bubble.
- Latency: press at edge t with output free gives evt_valid=1 and evt_id valid after edge t (1 cycle).
- Lockout:
  - A nonzero counter decrements by 1 per cycle; locked[i] = (counter[i] != 0).
  - A press in the same cycle as its own grant is absorbed and does not set overrun.
  - With LOCKOUT_CYCLES=0, locked never asserts.
- Overrun:
  - Cleared only by clr_overrun or reset.
  - If clr_overrun and a new overrun condition coincide, set wins.
- Widths: lockout counters are LOCK_W bits, with no wrap (decrement stops at 0). The pointer wraps modulo NUM_BTN, including non-power-of-2 NUM_BTN.

Decomposition:
- Shared package game_pkg holds:
  - default NUM_BTN;
  - button index constants BTN_P1, BTN_P2, BTN_SERVE, BTN_PAUSE;
  - default LOCKOUT_CYCLES.
- One sub-module rr_arbiter(NUM_BTN) takes cand and last_grant and returns a one-hot grant plus encoded index (combinational). The top block owns all state: pending, overrun, lockout counters, output register and pointer.

Test Plan (NUM_BTN=4, LOCKOUT_CYCLES=8, evt_ready=1 unless stated):
1. Reset then single press[2] pulse -> evt_valid=1, evt_id=2 one cycle later for exactly one cycle; locked[2]=1 for 8 cycles; other outputs 0.
2. press=4'b0011 in one cycle after reset -> events id 0 then id 1 on consecutive cycles. Repeat with last_grant=0 and press=4'b1001 -> order 3 then 0.
3. evt_ready=0, press[1] then press[3] -> evt_id=1 held stable; on evt_ready=1 -> transfer 1, then id 3 next cycle with no gap.
4. evt_ready=0, output already holding button 0, press[1] twice -> overrun[1]=1, only one id-1 event delivered; clr_overrun -> overrun=0.
5. press[0], then press[0] 3 cycles later -> second press dropped and overrun[0] stays 0; press[0] 10 cycles after grant -> new event.
6. enable=0 with press=4'b1111 -> no events; reset asserted while evt_valid=1 and evt_ready=0 -> evt_valid=0 and pending=0 after the edge.
